// File: rtl/axi_rd_arbiter_if.sv
// AXI read-channel bundle between N requesting masters, the arbiter and one slave.
// slave modport: arbiter view. master modport: environment (masters + slave model).
interface axi_rd_arbiter_if #(
   parameter int NUM_MST = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 8
);
   logic [NUM_MST-1:0]        ARVALID_M;
   logic [NUM_MST*ADDR_W-1:0] ARADDR_M;
   logic [NUM_MST*LEN_W-1:0]  ARLEN_M;
   logic [NUM_MST-1:0]        ARREADY_M;
   logic [NUM_MST-1:0]        RVALID_M;
   logic [NUM_MST-1:0]        RREADY_M;
   logic [DATA_W-1:0]         RDATA_M;
   logic [1:0]                RRESP_M;
   logic                      RLAST_M;
   logic                      ARVALID_S;
   logic [ADDR_W-1:0]         ARADDR_S;
   logic [LEN_W-1:0]          ARLEN_S;
   logic                      ARREADY_S;
   logic                      RVALID_S;
   logic [DATA_W-1:0]         RDATA_S;
   logic [1:0]                RRESP_S;
   logic                      RLAST_S;
   logic                      RREADY_S;

   modport slave (
      input  ARVALID_M, ARADDR_M, ARLEN_M, RREADY_M,
      input  ARREADY_S, RVALID_S, RDATA_S, RRESP_S, RLAST_S,
      output ARREADY_M, RVALID_M, RDATA_M, RRESP_M, RLAST_M,
      output ARVALID_S, ARADDR_S, ARLEN_S, RREADY_S
   );

   modport master (
      output ARVALID_M, ARADDR_M, ARLEN_M, RREADY_M,
      output ARREADY_S, RVALID_S, RDATA_S, RRESP_S, RLAST_S,
      input  ARREADY_M, RVALID_M, RDATA_M, RRESP_M, RLAST_M,
      input  ARVALID_S, ARADDR_S, ARLEN_S, RREADY_S
   );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Fixed-priority AXI read arbiter, one outstanding burst (index 0 wins).
// Ports: ACLK, ARESETn (sync, low), bus (slave modport), GNT one-hot, BUSY.
module axi_rd_arbiter #(
   parameter int NUM_MST = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 8
) (
   input  logic               ACLK,
   input  logic               ARESETn,
   axi_rd_arbiter_if.slave    bus,
   output logic [NUM_MST-1:0] GNT,
   output logic               BUSY
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;

   logic [1:0]         state;
   logic [NUM_MST-1:0] pick;
   logic               in_addr;
   logic               in_data;
   logic               arv_g;
   logic               rrdy_g;
   logic [ADDR_W-1:0]  addr_g;
   logic [LEN_W-1:0]   len_g;

   // Scan from the top so the lowest requesting index wins.
   always_comb begin
      pick = '0;
      for (int i = NUM_MST - 1; i >= 0; i--) begin
         if (bus.ARVALID_M[i]) begin
            pick    = '0;
            pick[i] = 1'b1;
         end
      end
   end

   // Granted-master mux; all zero when nothing is granted.
   always_comb begin
      arv_g  = 1'b0;
      rrdy_g = 1'b0;
      addr_g = '0;
      len_g  = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         if (GNT[i]) begin
            arv_g  = bus.ARVALID_M[i];
            rrdy_g = bus.RREADY_M[i];
            addr_g = bus.ARADDR_M[i*ADDR_W +: ADDR_W];
            len_g  = bus.ARLEN_M[i*LEN_W +: LEN_W];
         end
      end
   end

   // Reset gates handshakes even before the first reset edge.
   assign in_addr = ARESETn & (state == S_ADDR);
   assign in_data = ARESETn & (state == S_DATA);

   assign bus.ARVALID_S = in_addr & arv_g;
   assign bus.ARADDR_S  = addr_g;
   assign bus.ARLEN_S   = len_g;
   assign bus.ARREADY_M = in_addr ? (GNT & {NUM_MST{bus.ARREADY_S}}) : '0;
   assign bus.RVALID_M  = in_data ? (GNT & {NUM_MST{bus.RVALID_S}}) : '0;
   assign bus.RREADY_S  = in_data & rrdy_g;
   assign bus.RDATA_M   = bus.RDATA_S;
   assign bus.RRESP_M   = bus.RRESP_S;
   assign bus.RLAST_M   = bus.RLAST_S;
   assign BUSY          = ARESETn & (state != S_IDLE);

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state <= S_IDLE;
         GNT   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (|bus.ARVALID_M) begin
                  GNT   <= pick;
                  state <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (bus.ARVALID_S & bus.ARREADY_S)
                  state <= S_DATA;
            end
            S_DATA: begin
               // Only RLAST ends the burst; ARLEN is not tracked.
               if (bus.RVALID_S & bus.RREADY_S & bus.RLAST_S) begin
                  state <= S_IDLE;
                  GNT   <= '0;
               end
            end
            default: begin
               state <= S_IDLE;
               GNT   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios then random traffic,
// every cycle compared against an owner/phase transaction model.
module tb_axi_rd_arbiter;
   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 8;

   logic         ACLK = 1'b0;
   logic         ARESETn;
   logic [N-1:0] GNT;
   logic         BUSY;

   axi_rd_arbiter_if #(.NUM_MST(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

   axi_rd_arbiter #(.NUM_MST(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .bus     (bus),
      .GNT     (GNT),
      .BUSY    (BUSY)
   );

   always #5 ACLK = ~ACLK;

   int checks  = 0;
   int errs    = 0;
   int owner   = -1;
   bit accepted = 1'b0;
   int pulses1 = 0;

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      checks++;
      assert (o === e) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic check_outputs();
      logic [N-1:0] eg;
      bit act, aph, dph;
      act = ARESETn && (owner >= 0);
      aph = act && !accepted;
      dph = act && accepted;
      eg  = (owner >= 0) ? (N'(1) << owner) : '0;
      chk("gnt", GNT, eg);
      chk("busy", BUSY, act);
      chk("arvalid_s", bus.ARVALID_S, aph ? bus.ARVALID_M[owner] : 1'b0);
      chk("arready_m", bus.ARREADY_M, (aph && bus.ARREADY_S) ? eg : '0);
      chk("rvalid_m", bus.RVALID_M, (dph && bus.RVALID_S) ? eg : '0);
      chk("rready_s", bus.RREADY_S, dph ? bus.RREADY_M[owner] : 1'b0);
      chk("rdata_m", bus.RDATA_M, bus.RDATA_S);
      chk("rresp_last_m", {bus.RRESP_M, bus.RLAST_M}, {bus.RRESP_S, bus.RLAST_S});
      if (aph) begin
         chk("araddr_s", bus.ARADDR_S, bus.ARADDR_M[owner*AW +: AW]);
         chk("arlen_s", bus.ARLEN_S, bus.ARLEN_M[owner*LW +: LW]);
      end
   endtask

   // Transaction-level view: who owns the slave and whether its address went out.
   task automatic model_step();
      if (!ARESETn) begin
         owner    = -1;
         accepted = 1'b0;
      end else if (owner < 0) begin
         for (int i = N - 1; i >= 0; i--)
            if (bus.ARVALID_M[i]) owner = i;
         accepted = 1'b0;
      end else if (!accepted) begin
         if (bus.ARVALID_M[owner] && bus.ARREADY_S) accepted = 1'b1;
      end else if (bus.RVALID_S && bus.RREADY_M[owner] && bus.RLAST_S) begin
         owner = -1;
      end
   endtask

   task automatic cyc();
      @(negedge ACLK);
      check_outputs();
      if (bus.RVALID_M[1]) pulses1++;
      model_step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic idle_inputs();
      bus.ARVALID_M = '0;
      bus.ARADDR_M  = '0;
      bus.ARLEN_M   = '0;
      bus.RREADY_M  = '0;
      bus.ARREADY_S = 1'b0;
      bus.RVALID_S  = 1'b0;
      bus.RDATA_S   = '0;
      bus.RRESP_S   = '0;
      bus.RLAST_S   = 1'b0;
   endtask

   task automatic burst(input int n);
      bus.RREADY_M = '1;
      for (int b = 0; b < n; b++) begin
         bus.RVALID_S = 1'b1;
         bus.RDATA_S  = $urandom;
         bus.RRESP_S  = 2'($urandom);
         bus.RLAST_S  = (b == n - 1);
         cyc();
      end
      bus.RVALID_S = 1'b0;
      bus.RLAST_S  = 1'b0;
      bus.RREADY_M = '0;
   endtask

   initial begin
      idle_inputs();
      ARESETn = 1'b0;
      repeat (2) @(posedge ACLK);
      #1;
      cyc();
      chk("reset_gnt", GNT, 0);
      chk("reset_busy", BUSY, 0);
      ARESETn = 1'b1;
      cyc();

      // Simultaneous requests: master 0 wins.
      bus.ARADDR_M  = {32'hB000_0010, 32'hA000_0020};
      bus.ARLEN_M   = {8'd5, 8'd7};
      bus.ARVALID_M = 2'b11;
      bus.ARREADY_S = 1'b1;
      cyc();
      chk("r36_gnt", GNT, 2'b01);
      chk("r36_araddr", bus.ARADDR_S, 32'hA000_0020);
      chk("r36_arready_m", bus.ARREADY_M, 2'b01);
      cyc();
      bus.ARVALID_M = 2'b00;
      burst(1);
      chk("r36_done", GNT, 0);

      // Master 1 alone, four-beat burst.
      bus.ARVALID_M = 2'b10;
      bus.ARLEN_M   = {8'd3, 8'd0};
      cyc();
      chk("r37_gnt", GNT, 2'b10);
      cyc();
      bus.ARVALID_M = 2'b00;
      pulses1 = 0;
      burst(4);
      chk("r37_pulses", pulses1, 4);
      chk("r37_gnt_after", GNT, 0);
      chk("r37_busy_after", BUSY, 0);

      // No preemption by master 0 while master 1 holds the slave.
      bus.ARVALID_M = 2'b10;
      cyc();
      cyc();
      bus.ARVALID_M = 2'b01;
      repeat (3) cyc();
      chk("r38_hold", GNT, 2'b10);
      burst(2);
      chk("r38_idle", GNT, 0);
      cyc();
      chk("r38_next", GNT, 2'b01);
      cyc();
      bus.ARVALID_M = 2'b00;
      burst(1);

      // Slave stalls the address; then a dropped ARVALID in ADDR.
      bus.ARREADY_S = 1'b0;
      bus.ARADDR_M  = {32'h1111_1111, 32'hC0DE_0040};
      bus.ARVALID_M = 2'b01;
      cyc();
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("r39_arvalid", bus.ARVALID_S, 1'b1);
         chk("r39_araddr", bus.ARADDR_S, 32'hC0DE_0040);
         chk("r39_busy", BUSY, 1'b1);
      end
      bus.ARVALID_M = 2'b00;
      bus.ARREADY_S = 1'b1;
      repeat (2) cyc();
      chk("r30_gnt", GNT, 2'b01);
      bus.ARVALID_M = 2'b01;
      cyc();
      bus.ARVALID_M = 2'b00;
      burst(1);

      // Granted master not ready while the last beat is offered.
      bus.ARVALID_M = 2'b10;
      cyc();
      cyc();
      bus.ARVALID_M = 2'b00;
      bus.RREADY_M  = 2'b01;
      bus.RVALID_S  = 1'b1;
      bus.RLAST_S   = 1'b1;
      repeat (3) cyc();
      chk("r40_rready_s", bus.RREADY_S, 1'b0);
      chk("r40_gnt", GNT, 2'b10);
      bus.RREADY_M = 2'b10;
      cyc();
      chk("r40_done", GNT, 0);
      bus.RVALID_S = 1'b0;
      bus.RLAST_S  = 1'b0;
      bus.RREADY_M = 2'b00;

      // Reset in the middle of a data phase with both requests pending.
      bus.ARVALID_M = 2'b10;
      cyc();
      cyc();
      bus.ARVALID_M = 2'b11;
      bus.RREADY_M  = 2'b11;
      ARESETn = 1'b0;
      cyc();
      ARESETn = 1'b1;
      chk("r41_busy", BUSY, 1'b0);
      chk("r41_gnt", GNT, 0);
      chk("r41_rready_s", bus.RREADY_S, 1'b0);
      cyc();
      chk("r41_regrant", GNT, 2'b01);

      // Random traffic, including occasional resets and protocol abuse.
      for (int c = 0; c < 1500; c++) begin
         ARESETn       = ($urandom_range(0, 63) != 0);
         bus.ARVALID_M = N'($urandom);
         bus.ARADDR_M  = {$urandom, $urandom};
         bus.ARLEN_M   = 16'($urandom);
         bus.ARREADY_S = 1'($urandom);
         bus.RVALID_S  = 1'($urandom);
         bus.RREADY_M  = N'($urandom);
         bus.RLAST_S   = ($urandom_range(0, 3) == 0);
         bus.RDATA_S   = $urandom;
         bus.RRESP_S   = 2'($urandom);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter NUM_MST, default 2: number of requesting masters, range 2..8.
REQ-002 Parameter ADDR_W, default 32: AR address width.
REQ-003 Parameter DATA_W, default 32: R data width.
REQ-004 Parameter LEN_W, default 8: ARLEN width.
REQ-005 ACLK  in  1  the single clock; all state updates on its rising edge.
REQ-006 ARESETn  in  1  reset, synchronous, active-low.
REQ-007 ARVALID_M  in  NUM_MST  per-master read-address valid.
REQ-008 ARADDR_M  in  NUM_MST*ADDR_W  per-master address; master i in bits [i*ADDR_W +: ADDR_W].
REQ-009 ARLEN_M  in  NUM_MST*LEN_W  per-master burst length (beats minus 1), same packing.
REQ-010 ARREADY_M  out  NUM_MST  per-master read-address ready.
REQ-011 RVALID_M  out  NUM_MST  per-master read-data valid.
REQ-012 RREADY_M  in  NUM_MST  per-master read-data ready.
REQ-013 RDATA_M, RRESP_M, RLAST_M  out  DATA_W, 2, 1  read data/response/last, broadcast to all masters.
REQ-014 ARVALID_S, ARADDR_S, ARLEN_S  out  1, ADDR_W, LEN_W  slave-side address channel.
REQ-015 ARREADY_S  in  1  slave address ready.
REQ-016 RVALID_S, RDATA_S, RRESP_S, RLAST_S  in  1, DATA_W, 2, 1  slave read-data channel.
REQ-017 RREADY_S  out  1  slave read-data ready.
REQ-018 GNT  out  NUM_MST  registered one-hot grant; all-zero when idle.
REQ-019 BUSY  out  1  high in any state other than IDLE.

Function
REQ-020 FSM states: IDLE, ADDR, DATA; exactly one active per cycle.
REQ-021 IDLE: if any ARVALID_M bit set, GNT <= one-hot of lowest-index set bit (index 0 highest priority, index 0 grantable), next state ADDR; else stay IDLE, GNT = 0.
REQ-022 Arbitration latency: one cycle from ARVALID_M assertion in IDLE to ARVALID_S assertion.
REQ-023 ADDR: ARVALID_S, ARADDR_S, ARLEN_S combinationally muxed from granted master; ARREADY_M[g] = ARREADY_S; all other ARREADY_M bits 0.
REQ-024 ADDR -> DATA on cycle where ARVALID_S & ARREADY_S; otherwise hold ADDR and GNT.
REQ-025 DATA: RVALID_M[g] = RVALID_S, RREADY_S = RREADY_M[g]; all other RVALID_M bits 0; ARVALID_S = 0; all ARREADY_M = 0.
REQ-026 DATA -> IDLE on cycle where RVALID_S & RREADY_S & RLAST_S; GNT cleared same edge.
REQ-027 No preemption: requests from any master, including higher priority, do not alter GNT outside IDLE.
REQ-028 After return to IDLE, at least one IDLE cycle precedes the next grant (no back-to-back grant in the RLAST cycle).
REQ-029 Simultaneous requests from several masters: only the lowest index is granted; losers keep ARVALID_M asserted and see ARREADY_M = 0.
REQ-030 A granted master deasserting ARVALID_M in ADDR (protocol violation) holds ADDR with ARVALID_S = 0; no state change.
REQ-031 Single outstanding transaction: RLAST_S outside DATA is ignored; RREADY_S = 0 outside DATA.
REQ-032 ARLEN does not gate completion; RLAST_S alone ends the burst.

Reset
REQ-033 While ARESETn = 0 at a rising ACLK edge: state <= IDLE, GNT <= 0.
REQ-034 During and after reset: ARVALID_S = 0, RREADY_S = 0, all ARREADY_M = 0, all RVALID_M = 0, BUSY = 0.
REQ-035 Reset mid-transaction abandons it; first grant after release follows REQ-021 with no memory of prior grant.

Verification
REQ-036 NUM_MST=2, ARVALID_M=2'b11 in IDLE -> next cycle GNT=2'b01, ARADDR_S = master 0 address, ARREADY_M[1]=0.
REQ-037 Master 1 only, ARLEN=3, slave returns 4 beats with RLAST on 4th -> RVALID_M[1] pulses 4 times, RVALID_M[0]=0, GNT=0 cycle after 4th handshake.
REQ-038 Master 1 in DATA, master 0 asserts ARVALID_M -> GNT stays 2'b10 until RLAST handshake, then IDLE one cycle, then GNT=2'b01.
REQ-039 ARREADY_S held low 5 cycles in ADDR -> ARVALID_S and ARADDR_S stable 5 cycles, state stays ADDR.
REQ-040 RREADY_M[g]=0 with RVALID_S=1 and RLAST_S=1 -> RREADY_S=0, state stays DATA until RREADY_M[g]=1.
REQ-041 ARESETn low for 1 cycle mid-DATA -> next cycle BUSY=0, GNT=0, RREADY_S=0; pending request re-granted per priority.
